// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   state_t   : access sequencer states
//   SRAM_DW   : SRAM data width (half-word)
//   SRAM_AW   : SRAM half-word address width
//   BASE_ADDR : default byte address mapped to SRAM word 0
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PH_LO = 2'd1,
    PH_HI = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          SRAM_DW   = 16;
  localparam int          SRAM_AW   = 18;
  localparam logic [31:0] BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter for the SRAM controller.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart count from zero (wins over en)
//   en       : count this cycle
//   tc       : high on the last cycle of a WAIT_CYCLES-long phase
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  assign tc = en && (cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage data memory controller for a 16-bit asynchronous SRAM.
// Each 32-bit load/store runs as two half-word phases (low, then high),
// each held WAIT_CYCLES cycles; ready freezes the pipeline meanwhile.
//   clk, rst     : clock, asynchronous active-high reset
//   wr_en, rd_en : store / load request from MEM stage
//   address      : byte address (ALU result)
//   write_data   : store value
//   read_data    : load result (holds until the next read completes)
//   ready        : 1 = no access pending or access finishing this cycle
//   sram_addr    : SRAM half-word address
//   sram_we_n    : SRAM write strobe, active low
//   sram_dq_out  : data driven to SRAM, sram_dq_oe enables the driver
//   sram_dq_in   : data read back from SRAM
module sram_mem_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = arm_mem_pkg::BASE_ADDR,
  parameter int          WAIT_CYCLES = 3,
  parameter int          SRAM_AW     = arm_mem_pkg::SRAM_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic                ready,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic                sram_we_n,
  output logic [SRAM_DW-1:0]  sram_dq_out,
  output logic                sram_dq_oe,
  input  logic [SRAM_DW-1:0]  sram_dq_in
);

  localparam int WW = SRAM_AW - 1;

  state_t            state, state_nxt;
  logic              req, accept, in_phase;
  logic              cnt_clr, cnt_en, tc;
  logic [WW-1:0]     word_q, word_in;
  logic [31:0]       data_q;
  logic              op_wr_q;
  logic [SRAM_DW-1:0] rd_lo_q;

  assign req    = rd_en | wr_en;
  assign accept = (state == IDLE) && req;

  // Byte offset from the SRAM window, dropped to a 32-bit word index;
  // out-of-window addresses simply wrap.
  assign word_in = WW'((address - BASE_ADDR) >> 2);

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Counter is cleared on every phase entry so each phase gets a full wait.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (req) state_nxt = PH_LO;
      end
      PH_LO: begin
        cnt_en = 1'b1;
        if (tc) begin
          state_nxt = PH_HI;
          cnt_clr   = 1'b1;
        end
      end
      PH_HI: begin
        cnt_en = 1'b1;
        if (tc) begin
          state_nxt = DONE;
          cnt_clr   = 1'b1;
        end
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latches; a simultaneous rd_en/wr_en is treated as a write.
  // The low read half is staged so read_data only changes on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      data_q    <= '0;
      op_wr_q   <= 1'b0;
      rd_lo_q   <= '0;
      read_data <= '0;
    end else begin
      if (accept) begin
        word_q  <= word_in;
        data_q  <= write_data;
        op_wr_q <= wr_en;
      end
      if ((state == PH_LO) && tc && !op_wr_q)
        rd_lo_q <= sram_dq_in;
      if ((state == PH_HI) && tc && !op_wr_q)
        read_data <= {sram_dq_in, rd_lo_q};
    end
  end

  assign in_phase = (state == PH_LO) || (state == PH_HI);

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    case (state)
      PH_LO: begin
        sram_addr = {word_q, 1'b0};
        if (op_wr_q) sram_dq_out = data_q[15:0];
      end
      PH_HI: begin
        sram_addr = {word_q, 1'b1};
        if (op_wr_q) sram_dq_out = data_q[31:16];
      end
      default: ;
    endcase
  end

  assign sram_we_n  = ~(op_wr_q && in_phase);
  assign sram_dq_oe = op_wr_q && in_phase;
  assign ready      = ((state == IDLE) && !req) || (state == DONE);

endmodule

// File: tb/tb_sram_mem_controller.sv
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:(1<<18)-1];

  always #5 clk = ~clk;

  sram_mem_controller dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_we_n   (sram_we_n),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in)
  );

  // Behavioural asynchronous SRAM: combinational read, write while we_n low.
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] exp_seq [1:14];

  initial begin
    for (int i = 0; i < (1<<18); i++) mem[i] = 16'h0000;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    step();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_ready", {31'd0, ready}, 32'd1);

    // Write 0xDEADBEEF to 1032 -> half-words 4 (low) and 5 (high)
    wr_en = 1'b1; address = 32'd1032; write_data = 32'hDEADBEEF;
    #1 chk("wr_req_ready", {31'd0, ready}, 32'd0);
    step();
    wr_en = 1'b0; address = 32'hFFFF_FFF0; write_data = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("wr_addr_c%0d", c), {14'd0, sram_addr}, (c <= 3) ? 32'd4 : 32'd5);
      chk($sformatf("wr_dq_c%0d", c), {16'd0, sram_dq_out}, (c <= 3) ? 32'hBEEF : 32'hDEAD);
      chk($sformatf("wr_we_c%0d", c), {31'd0, sram_we_n}, 32'd0);
      chk($sformatf("wr_oe_c%0d", c), {31'd0, sram_dq_oe}, 32'd1);
      chk($sformatf("wr_rdy_c%0d", c), {31'd0, ready}, 32'd0);
      step();
    end
    chk("wr_done_ready", {31'd0, ready}, 32'd1);
    chk("wr_done_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("wr_done_addr", {14'd0, sram_addr}, 32'd0);
    step();
    chk("wr_mem4", {16'd0, mem[4]}, 32'hBEEF);
    chk("wr_mem5", {16'd0, mem[5]}, 32'hDEAD);
    chk("wr_idle_ready", {31'd0, ready}, 32'd1);

    // Read back 1032
    rd_en = 1'b1; address = 32'd1032;
    #1 chk("rd_c0_ready", {31'd0, ready}, 32'd0);
    step();
    rd_en = 1'b0; address = 32'd0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("rd_rdy_c%0d", c), {31'd0, ready}, 32'd0);
      chk($sformatf("rd_we_c%0d", c), {31'd0, sram_we_n}, 32'd1);
      chk($sformatf("rd_oe_c%0d", c), {31'd0, sram_dq_oe}, 32'd0);
      step();
    end
    chk("rd_done_ready", {31'd0, ready}, 32'd1);
    chk("rd_data", read_data, 32'hDEADBEEF);
    step(); step();
    chk("rd_data_hold", read_data, 32'hDEADBEEF);

    // Write 1024 then read 1028 back-to-back
    exp_seq = '{18'd0, 18'd0, 18'd0, 18'd1, 18'd1, 18'd1, 18'd0,
                18'd0, 18'd2, 18'd2, 18'd2, 18'd3, 18'd3, 18'd3};
    mem[2] = 16'h5555; mem[3] = 16'hAAAA;
    wr_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
    step();
    wr_en = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("b2b_addr_c%0d", c), {14'd0, sram_addr}, {14'd0, exp_seq[c]});
      if (c == 7) begin
        rd_en = 1'b1; address = 32'd1028;
      end
      if (c == 9) rd_en = 1'b0;
      step();
    end
    chk("b2b_ready", {31'd0, ready}, 32'd1);
    chk("b2b_rdata", read_data, 32'hAAAA5555);
    chk("b2b_mem0", {16'd0, mem[0]}, 32'h2222);
    chk("b2b_mem1", {16'd0, mem[1]}, 32'h1111);
    step();

    // Simultaneous rd_en & wr_en: write wins, read_data unchanged
    rd_en = 1'b1; wr_en = 1'b1; address = 32'd1040; write_data = 32'h12345678;
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("both_we_n", {31'd0, sram_we_n}, 32'd0);
    chk("both_addr", {14'd0, sram_addr}, 32'd8);
    for (int c = 1; c <= 6; c++) step();
    chk("both_ready", {31'd0, ready}, 32'd1);
    step();
    chk("both_mem8", {16'd0, mem[8]}, 32'h5678);
    chk("both_mem9", {16'd0, mem[9]}, 32'h1234);
    chk("both_rdata", read_data, 32'hAAAA5555);

    // Reset during cycle 4 of a write: high half must not be written
    wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
    step();
    wr_en = 1'b0;
    step(); step(); step();
    chk("rw_c4_addr", {14'd0, sram_addr}, 32'd5);
    chk("rw_c4_we_n", {31'd0, sram_we_n}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rw_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rw_addr", {14'd0, sram_addr}, 32'd0);
    chk("rw_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rw_ready", {31'd0, ready}, 32'd1);
    chk("rw_rdata", read_data, 32'h0);
    step();
    rst = 1'b0;
    chk("rw_mem4", {16'd0, mem[4]}, 32'hF00D);
    chk("rw_mem5", {16'd0, mem[5]}, 32'hDEAD);
    rd_en = 1'b1; address = 32'd1032;
    step();
    rd_en = 1'b0;
    chk("rw_new_addr", {14'd0, sram_addr}, 32'd4);
    for (int c = 1; c <= 6; c++) step();
    chk("rw_new_ready", {31'd0, ready}, 32'd1);
    chk("rw_new_rdata", read_data, 32'hDEADF00D);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
